// File: rtl/traffic_ctrl_2way_pkg.sv
// Shared light codes and controller state encoding for the two-approach
// intersection; also used by display and verification blocks.
package traffic_ctrl_2way_pkg;

  localparam logic [1:0] LED_RED    = 2'b00;
  localparam logic [1:0] LED_GREEN  = 2'b01;
  localparam logic [1:0] LED_YELLOW = 2'b10;
  localparam logic [1:0] LED_OFF    = 2'b11;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    CLR_AB   = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    CLR_BA   = 3'd5,
    FLASH    = 3'd6
  } state_t;

endpackage

// File: rtl/traffic_ctrl_2way_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clock cycles.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;

  // rst_n is active high despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick = (r_count == LAST);

endmodule

// File: rtl/traffic_ctrl_2way.sv
// Two-approach intersection light controller: phase FSM, per-second phase
// timer, pedestrian request latch and night flashing mode.
module traffic_ctrl_2way
  import traffic_ctrl_2way_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int GREEN_S     = 15,
  parameter int YELLOW_S    = 3,
  parameter int ALLRED_S    = 1,
  parameter int MIN_GREEN_S = 5,
  parameter int TW          = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          night_mode,
  input  logic          ped_req,
  output logic [1:0]    led_a,
  output logic [1:0]    led_b,
  output logic [TW-1:0] timer_value,
  output logic          ped_walk
);

  localparam logic [TW-1:0] T_GREEN  = TW'(GREEN_S);
  localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_S);
  localparam logic [TW-1:0] T_ALLRED = TW'(ALLRED_S);
  localparam logic [TW-1:0] T_MIN    = TW'(MIN_GREEN_S);
  localparam logic [TW-1:0] T_ONE    = TW'(1);

  logic          w_tick;
  state_t        r_state, w_state_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic [1:0]    r_led_a, w_led_a_next;
  logic [1:0]    r_led_b, w_led_b_next;
  logic          r_pend, w_pend_next;
  logic          r_served, w_served_next;
  logic          r_walk, w_walk_next;
  logic          r_flash, w_flash_next;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state  <= CLR_BA;
      r_timer  <= T_ALLRED;
      r_led_a  <= LED_RED;
      r_led_b  <= LED_RED;
      r_pend   <= 1'b0;
      r_served <= 1'b0;
      r_walk   <= 1'b0;
      r_flash  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_timer  <= w_timer_next;
      r_led_a  <= w_led_a_next;
      r_led_b  <= w_led_b_next;
      r_pend   <= w_pend_next;
      r_served <= w_served_next;
      r_walk   <= w_walk_next;
      r_flash  <= w_flash_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_timer_next  = r_timer;
    w_pend_next   = r_pend | ped_req;
    w_served_next = r_served;
    w_walk_next   = r_walk;
    w_flash_next  = r_flash;

    case (r_state)
      A_GREEN, B_GREEN: begin
        if (w_tick) begin
          if (r_pend && (r_timer > T_MIN)) begin
            w_timer_next = T_MIN;
          end else if (r_timer == T_ONE) begin
            // The latched request is handed to this green; a request in the
            // same cycle stays pending for the next green.
            w_state_next  = (r_state == A_GREEN) ? A_YELLOW : B_YELLOW;
            w_timer_next  = T_YELLOW;
            w_served_next = r_pend;
            w_pend_next   = ped_req;
          end else begin
            w_timer_next = r_timer - 1'b1;
          end
        end
      end
      A_YELLOW, B_YELLOW: begin
        if (w_tick) begin
          if (r_timer == T_ONE) begin
            w_state_next  = (r_state == A_YELLOW) ? CLR_AB : CLR_BA;
            w_timer_next  = T_ALLRED;
            w_walk_next   = r_served;
            w_served_next = 1'b0;
          end else begin
            w_timer_next = r_timer - 1'b1;
          end
        end
      end
      CLR_AB, CLR_BA: begin
        if (w_tick) begin
          if (r_timer == T_ONE) begin
            w_walk_next = 1'b0;
            if (night_mode) begin
              w_state_next = FLASH;
              w_timer_next = '0;
              w_flash_next = 1'b0;
            end else begin
              w_state_next = (r_state == CLR_AB) ? B_GREEN : A_GREEN;
              w_timer_next = T_GREEN;
            end
          end else begin
            w_timer_next = r_timer - 1'b1;
          end
        end
      end
      FLASH: begin
        if (w_tick) begin
          if (!night_mode) begin
            w_state_next = CLR_BA;
            w_timer_next = T_ALLRED;
          end else begin
            w_flash_next = ~r_flash;
          end
        end
      end
      default: begin
        w_state_next  = CLR_BA;
        w_timer_next  = T_ALLRED;
        w_walk_next   = 1'b0;
        w_served_next = 1'b0;
        w_flash_next  = 1'b0;
      end
    endcase

    // Lights are decoded from the next state so they register with it
    w_led_a_next = LED_RED;
    w_led_b_next = LED_RED;
    case (w_state_next)
      A_GREEN:  w_led_a_next = LED_GREEN;
      A_YELLOW: w_led_a_next = LED_YELLOW;
      B_GREEN:  w_led_b_next = LED_GREEN;
      B_YELLOW: w_led_b_next = LED_YELLOW;
      FLASH: begin
        w_led_a_next = w_flash_next ? LED_OFF : LED_YELLOW;
        w_led_b_next = w_flash_next ? LED_OFF : LED_YELLOW;
      end
      default: ;
    endcase
  end

  assign led_a       = r_led_a;
  assign led_b       = r_led_b;
  assign timer_value = r_timer;
  assign ped_walk    = r_walk;

endmodule
